// File: rtl/adder_bitserial.sv
// Bit-serial adder: one bit column per clock, LSB first, through a single carry flop.
// Operands are captured on the accepting edge; Sum/Cout/Ovf are registered at completion.
module adder_bitserial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  // state | meaning
  // IDLE  | waiting for start, ready=1
  // RUN   | one bit column per edge, ready=0
  // DONE  | results fresh this cycle, done=1, ready=1
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_ready;
  logic               w_done;

  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_s_sh;
  logic               r_c;
  logic               r_c_msb;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_s;
  logic               w_cn;
  logic               w_last;
  logic               w_load;
  logic [WIDTH-1:0]   w_s_sh_nxt;
  logic               w_unused;

  assign w_s    = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
  assign w_cn   = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_c) | (r_b_sh[0] & r_c);
  assign w_last = (r_cnt == CNT_LAST);
  assign w_load = w_ready & start;

  // New sum bit enters at the MSB so that after WIDTH shifts bit i sits at index i.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_s_sh_nxt = w_s;
    end else begin : g_wn
      assign w_s_sh_nxt = {w_s, r_s_sh[WIDTH-1:1]};
    end
  endgenerate

  // Carry-into-MSB is kept for debug visibility; s_sh LSB is simply shifted out.
  assign w_unused = ^{r_s_sh[0], r_c_msb};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_ready = 1'b1;
        w_done  = 1'b1;
        w_state_nxt = start ? RUN : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_c     <= 1'b0;
      r_c_msb <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a_sh <= A;
      r_b_sh <= B;
      r_c    <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == RUN) begin
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
      r_s_sh <= w_s_sh_nxt;
      r_c    <= w_cn;
      r_cnt  <= r_cnt + CNT_W'(1);
      if (w_last) begin
        // r_c here is the carry into the MSB column.
        r_c_msb <= r_c;
        r_sum   <= w_s_sh_nxt;
        r_cout  <= w_cn;
        r_ovf   <= w_cn ^ r_c;
      end
    end
  end

  assign ready = w_ready;
  assign done  = w_done;
  assign Sum   = r_sum;
  assign Cout  = r_cout;
  assign Ovf   = r_ovf;

endmodule

// File: tb/tb_adder_bitserial.sv
// Scoreboard bench for adder_bitserial: WIDTH=8 main instance plus a WIDTH=1 instance.
// Expected results are queued at acceptance and checked by an independent done monitor.
module tb_adder_bitserial;
  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic         ready;
  logic         done;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;

  logic         start1 = 1'b0;
  logic [0:0]   a1     = '0;
  logic [0:0]   b1     = '0;
  logic         ready1;
  logic         done1;
  logic [0:0]   sum1;
  logic         cout1;
  logic         ovf1;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           c0;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  logic [W-1:0] last_sum  = '0;
  logic         last_cout = 1'b0;
  logic         last_ovf  = 1'b0;
  bit           b2b       = 1'b0;
  int           last_done = -1;

  adder_bitserial #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .ready(ready), .done(done), .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
  );

  adder_bitserial #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1),
    .ready(ready1), .done(done1), .Sum(sum1), .Cout(cout1), .Ovf(ovf1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t       e;
    logic [W:0] t;
    t      = {1'b0, a} + {1'b0, b};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    e.c0   = 0;
    return e;
  endfunction

  // Waits for ready, presents operands for the accepting edge, queues the expectation,
  // then disturbs A/B so that any late sampling of the inputs shows up as a wrong result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] esum,
                       input logic ecout, input logic eovf, input bit hold);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("ready_timeout", 64'(ready), 64'(1));
      return;
    end
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.sum  = esum;
    e.cout = ecout;
    e.ovf  = eovf;
    e.c0   = cyc;
    sb_q.push_back(e);
    if (!hold) start = 1'b0;
    A = ~a;
    B = a ^ b ^ 8'h5C;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb_q.size()), 64'(0));
    @(negedge clk);
  endtask

  task automatic run_w1();
    logic [3:0] w1_sum;
    logic [3:0] w1_cov;
    logic [1:0] ab;
    w1_sum = 4'b0110;
    w1_cov = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      @(negedge clk);
      chk("w1_ready", 64'(ready1), 64'(1));
      a1     = ab[1];
      b1     = ab[0];
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      @(negedge clk);
      chk("w1_done_early", 64'(done1), 64'(0));
      @(negedge clk);
      chk("w1_done", 64'(done1), 64'(1));
      chk("w1_sum",  64'(sum1),  64'(w1_sum[i]));
      chk("w1_cout", 64'(cout1), 64'(w1_cov[i]));
      chk("w1_ovf",  64'(ovf1),  64'(w1_cov[i]));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("spurious_done", 64'(done), 64'(0));
        end else begin
          mon_e = sb_q.pop_front();
          chk("latency", 64'(cyc - mon_e.c0), 64'(W));
          chk("sum",  64'(Sum),  64'(mon_e.sum));
          chk("cout", 64'(Cout), 64'(mon_e.cout));
          chk("ovf",  64'(Ovf),  64'(mon_e.ovf));
          if (b2b && last_done >= 0) chk("period", 64'(cyc - last_done), 64'(W + 1));
          last_done = cyc;
          last_sum  = mon_e.sum;
          last_cout = mon_e.cout;
          last_ovf  = mon_e.ovf;
        end
      end else if (!ready) begin
        chk("hold_sum",  64'(Sum),  64'(last_sum));
        chk("hold_cout", 64'(Cout), 64'(last_cout));
        chk("hold_ovf",  64'(Ovf),  64'(last_ovf));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_done",  64'(done),  64'(0));
    chk("rst_sum",   64'(Sum),   64'(8'h00));
    chk("rst_cout",  64'(Cout),  64'(0));
    chk("rst_ovf",   64'(Ovf),   64'(0));
    chk("rst_ready1", 64'(ready1), 64'(1));
    chk("rst_sum1",   64'(sum1),   64'(0));
    rst_n = 1'b1;

    run_w1();

    issue(8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1, 1'b0);
    issue(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
    issue(8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0);
    issue(8'h7F, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b0);
    drain();

    b2b       = 1'b1;
    last_done = -1;
    issue(8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b1);
    issue(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1);
    issue(8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0, 1'b1);
    issue(8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b1);
    issue(8'h90, 8'h90, 8'h20, 1'b1, 1'b1, 1'b1);
    start = 1'b0;
    drain();
    b2b = 1'b0;

    issue(8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 64'(ready), 64'(1));
    chk("abort_done",  64'(done),  64'(0));
    chk("abort_sum",   64'(Sum),   64'(8'h00));
    chk("abort_cout",  64'(Cout),  64'(0));
    chk("abort_ovf",   64'(Ovf),   64'(0));
    sb_q.delete();
    last_sum  = '0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      e  = model(ra, rb);
      issue(ra, rb, e.sum, e.cout, e.ovf, 1'b0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
